menu_button_pixel_gen: RTL and testbench

//  Next-generation menu pixel generator for the VGA path. Fetches a palette code per pixel from an

---
 rtl/menu_pkg.sv | 37 +++
 rtl/menu_button_fsm.sv | 60 ++++++
 rtl/menu_button_pixel_gen.sv | 130 +++++++++++++
 tb/tb_menu_button_pixel_gen.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/menu_pkg.sv
// Shared palette, link-status and button-state definitions for the menu pixel path.
package menu_pkg;

    localparam logic [11:0] BLACK   = 12'h000;
    localparam logic [11:0] WHITE   = 12'hFFF;
    localparam logic [11:0] TOUCH   = 12'h32E;
    localparam logic [11:0] CLICK   = 12'hDD2;
    localparam logic [11:0] RX_PEND = 12'h7FF;
    localparam logic [11:0] TX_PEND = 12'h456;
    localparam logic [11:0] LINKED  = 12'h1E1;

    typedef enum logic [1:0] {
        LINK_IDLE    = 2'd0,
        LINK_RX_PEND = 2'd1,
        LINK_TX_PEND = 2'd2,
        LINK_LINKED  = 2'd3
    } link_status_t;

    typedef enum logic [1:0] {
        BTN_IDLE      = 2'd0,
        BTN_HOVER     = 2'd1,
        BTN_PRESS     = 2'd2,
        BTN_ARMED_OFF = 2'd3
    } btn_state_t;

    // Link status outranks the pointer, except that a press beats pending indications.
    function automatic logic [11:0] btn_color(input btn_state_t st, input link_status_t ls,
                                              input logic phase);
        if (ls == LINK_LINKED)  return LINKED;
        if (st == BTN_PRESS)    return CLICK;
        if (ls == LINK_RX_PEND) return phase ? RX_PEND : BLACK;
        if (ls == LINK_TX_PEND) return TX_PEND;
        if (st == BTN_HOVER)    return TOUCH;
        return BLACK;
    endfunction

endpackage

// File: rtl/menu_button_fsm.sv
// Per-button hover/press/click tracker.
// Latency: state and click pulse register on the clock after the mouse inputs.
// Backpressure: none; reacts every cycle.
module menu_button_fsm
    import menu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       hover,
    input  logic       mouse_left,
    input  logic [1:0] link_status,
    output logic [1:0] state,
    output logic       click
);

    btn_state_t state_q;
    btn_state_t state_d;
    logic       click_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BTN_IDLE;
            click   <= 1'b0;
        end else begin
            state_q <= state_d;
            click   <= click_d;
        end
    end

    always_comb begin
        state_d = state_q;
        click_d = 1'b0;
        case (state_q)
            BTN_IDLE: begin
                // A press that started elsewhere never arms this button.
                if (hover && !mouse_left) state_d = BTN_HOVER;
            end
            BTN_HOVER: begin
                if (!hover)          state_d = BTN_IDLE;
                else if (mouse_left) state_d = BTN_PRESS;
            end
            BTN_PRESS: begin
                if (!hover) begin
                    state_d = BTN_ARMED_OFF;
                end else if (!mouse_left) begin
                    state_d = BTN_HOVER;
                    click_d = (link_status != LINK_LINKED);
                end
            end
            BTN_ARMED_OFF: begin
                if (!mouse_left) state_d = BTN_IDLE;
                else if (hover)  state_d = BTN_PRESS;
            end
            default: state_d = BTN_IDLE;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/menu_button_pixel_gen.sv
// Menu image fetch + palette mapping with per-button hover/press/link colouring.
// Latency: pixel_out/pixel_valid follow h_cnt/v_cnt/video_valid by MEM_LATENCY+2 cycles.
// Backpressure: none; free-running with the sync counter.
module menu_button_pixel_gen
    import menu_pkg::*;
#(
    parameter int NUM_BUTTONS  = 4,
    parameter int CODE_W       = 4,
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int SCALE_SHIFT  = 1,
    parameter int ADDR_W       = 17,
    parameter int MEM_LATENCY  = 1,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [9:0]                     h_cnt,
    input  logic [9:0]                     v_cnt,
    input  logic                           video_valid,
    input  logic [$clog2(NUM_BUTTONS)-1:0] mouse_btn_id,
    input  logic                           mouse_on_btn,
    input  logic                           mouse_left,
    input  logic [2*NUM_BUTTONS-1:0]       btn_status,
    output logic [ADDR_W-1:0]              mem_addr,
    input  logic [CODE_W-1:0]              mem_data,
    output logic [11:0]                    pixel_out,
    output logic                           pixel_valid,
    output logic [NUM_BUTTONS-1:0]         btn_click
);

    localparam int ID_W    = $clog2(NUM_BUTTONS);
    localparam int ROW_W   = H_RES >> SCALE_SHIFT;
    localparam int PIX_CNT = (H_RES * V_RES) >> (2 * SCALE_SHIFT);
    localparam int BW      = $clog2(BLINK_FRAMES + 1);

    // Address generation
    logic [31:0] addr_lin;
    assign addr_lin = 32'(h_cnt >> SCALE_SHIFT) + 32'(ROW_W) * 32'(v_cnt >> SCALE_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) mem_addr <= '0;
        else     mem_addr <= ADDR_W'(addr_lin % 32'(PIX_CNT));
    end

    // vld_pipe[MEM_LATENCY] lines up with the ROM data for the same pixel.
    logic [MEM_LATENCY:0] vld_pipe;

    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[MEM_LATENCY-1:0], video_valid};
    end

    // Frame tick on the first cycle at the origin only, so a held origin counts once.
    logic          at_origin;
    logic          at_origin_q;
    logic          frame_tick;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    assign at_origin  = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    assign frame_tick = at_origin && !at_origin_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            at_origin_q <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            at_origin_q <= at_origin;
            if (frame_tick) begin
                if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    logic [2*NUM_BUTTONS-1:0] status_q;

    always_ff @(posedge clk) begin
        if (rst) status_q <= '0;
        else     status_q <= btn_status;
    end

    logic [1:0]  btn_st  [NUM_BUTTONS];
    logic [11:0] btn_col [NUM_BUTTONS];

    for (genvar k = 0; k < NUM_BUTTONS; k++) begin : g_btn
        logic hover_k;
        assign hover_k = mouse_on_btn && (mouse_btn_id == ID_W'(k));

        menu_button_fsm u_fsm (
            .clk         (clk),
            .rst         (rst),
            .hover       (hover_k),
            .mouse_left  (mouse_left),
            .link_status (status_q[2*k +: 2]),
            .state       (btn_st[k]),
            .click       (btn_click[k])
        );

        assign btn_col[k] = btn_color(btn_state_t'(btn_st[k]),
                                      link_status_t'(status_q[2*k +: 2]), blink_phase);
    end

    // Palette: 0 black, button codes from the per-button colours, anything else white.
    logic [11:0] code_col;

    always_comb begin
        code_col = (mem_data == '0) ? BLACK : WHITE;
        for (int k = 0; k < NUM_BUTTONS; k++) begin
            if (mem_data == CODE_W'(k + 2)) code_col = btn_col[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_out   <= BLACK;
            pixel_valid <= 1'b0;
        end else begin
            pixel_out   <= vld_pipe[MEM_LATENCY] ? code_col : BLACK;
            pixel_valid <= vld_pipe[MEM_LATENCY];
        end
    end

endmodule

// File: tb/tb_menu_button_pixel_gen.sv
// Directed vector bench for menu_button_pixel_gen with a small ROM model.
module tb_menu_button_pixel_gen;

    localparam int NB   = 4;
    localparam int ML   = 1;
    localparam int PIPE = ML + 1;
    localparam int NV   = 16;

    logic        clk;
    logic        rst;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        video_valid;
    logic [1:0]  mouse_btn_id;
    logic        mouse_on_btn;
    logic        mouse_left;
    logic [7:0]  btn_status;
    logic [16:0] mem_addr;
    logic [3:0]  mem_data;
    logic [11:0] pixel_out;
    logic        pixel_valid;
    logic [3:0]  btn_click;

    int n_vec = 0;
    int n_err = 0;
    int click_cnt = 0;

    menu_button_pixel_gen #(.NUM_BUTTONS(NB), .MEM_LATENCY(ML), .BLINK_FRAMES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .h_cnt        (h_cnt),
        .v_cnt        (v_cnt),
        .video_valid  (video_valid),
        .mouse_btn_id (mouse_btn_id),
        .mouse_on_btn (mouse_on_btn),
        .mouse_left   (mouse_left),
        .btn_status   (btn_status),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .pixel_out    (pixel_out),
        .pixel_valid  (pixel_valid),
        .btn_click    (btn_click)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM model with ML cycles of read latency
    logic [3:0] rom [76800];
    logic [3:0] mem_pipe [ML];

    always @(posedge clk) begin
        mem_pipe[0] <= rom[mem_addr];
        for (int i = 1; i < ML; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign mem_data = mem_pipe[ML-1];

    typedef struct {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        vld;
        logic [16:0] exp_addr;
        logic [11:0] exp_pix;
    } vec_t;

    vec_t tbl [NV];

    task automatic step();
        @(posedge clk);
        #1;
        click_cnt += $countones(btn_click);
    endtask

    task automatic wait3();
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        video_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < 76800; a++) rom[a] = 4'(a % 8);
        rst = 1'b1; h_cnt = '0; v_cnt = '0; video_valid = 1'b0;
        mouse_btn_id = '0; mouse_on_btn = 1'b0; mouse_left = 1'b0; btn_status = '0;

        tbl[0]  = '{10'd0,    10'd0,    1'b1, 17'd0,     12'h000};
        tbl[1]  = '{10'd2,    10'd0,    1'b1, 17'd1,     12'hFFF};
        tbl[2]  = '{10'd5,    10'd0,    1'b1, 17'd2,     12'h000};
        tbl[3]  = '{10'd6,    10'd1,    1'b1, 17'd3,     12'h000};
        tbl[4]  = '{10'd8,    10'd0,    1'b1, 17'd4,     12'h456};
        tbl[5]  = '{10'd10,   10'd0,    1'b1, 17'd5,     12'h1E1};
        tbl[6]  = '{10'd12,   10'd0,    1'b1, 17'd6,     12'hFFF};
        tbl[7]  = '{10'd15,   10'd1,    1'b1, 17'd7,     12'hFFF};
        tbl[8]  = '{10'd0,    10'd2,    1'b1, 17'd320,   12'h000};
        tbl[9]  = '{10'd9,    10'd3,    1'b1, 17'd324,   12'h456};
        tbl[10] = '{10'd639,  10'd479,  1'b1, 17'd76799, 12'hFFF};
        tbl[11] = '{10'd0,    10'd0,    1'b0, 17'd0,     12'h000};
        tbl[12] = '{10'd1023, 10'd1023, 1'b0, 17'd10431, 12'h000};
        tbl[13] = '{10'd1,    10'd0,    1'b1, 17'd0,     12'h000};
        tbl[14] = '{10'd26,   10'd0,    1'b1, 17'd13,    12'h1E1};
        tbl[15] = '{10'd3,    10'd1,    1'b1, 17'd1,     12'hFFF};

        // Reset state
        do_reset();
        chk("rst_addr",  32'(mem_addr), 32'd0);
        chk("rst_pix",   32'(pixel_out), 32'h000);
        chk("rst_vld",   32'(pixel_valid), 32'd0);
        chk("rst_click", 32'(btn_click), 32'd0);

        // Table: address map, palette, buttons 3 linked / 2 tx-pending
        btn_status = 8'b11_10_00_00;
        step();
        for (int i = 0; i < NV + PIPE; i++) begin
            if (i < NV) begin
                h_cnt = tbl[i].h; v_cnt = tbl[i].v; video_valid = tbl[i].vld;
            end else begin
                h_cnt = 10'd100; v_cnt = 10'd100; video_valid = 1'b0;
            end
            step();
            if (i < NV) chk($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(tbl[i].exp_addr));
            if (i >= PIPE) begin
                chk($sformatf("tbl%0d_pix", i - PIPE), 32'(pixel_out), 32'(tbl[i-PIPE].exp_pix));
                chk($sformatf("tbl%0d_vld", i - PIPE), 32'(pixel_valid), 32'(tbl[i-PIPE].vld));
            end
        end

        // Full line of white pixels, valid from MEM_LATENCY+2 cycles after first valid
        for (int a = 0; a < 320; a++) rom[a] = 4'd1;
        do_reset();
        for (int i = 0; i < 640 + PIPE; i++) begin
            if (i < 640) begin
                h_cnt = 10'(i); v_cnt = 10'd0; video_valid = 1'b1;
            end else begin
                video_valid = 1'b0;
            end
            step();
            if (i < 640) chk("line_addr", 32'(mem_addr), 32'(i >> 1));
            chk("line_vld", 32'(pixel_valid), (i >= PIPE) ? 32'd1 : 32'd0);
            if (i >= PIPE) chk("line_pix", 32'(pixel_out), 32'hFFF);
        end
        for (int a = 0; a < 320; a++) rom[a] = 4'(a % 8);

        // Button 2 click sequence on a code-4 pixel
        btn_status = '0; h_cnt = 10'd8; v_cnt = 10'd0; video_valid = 1'b1;
        wait3();
        click_cnt = 0;
        chk("b2_idle", 32'(pixel_out), 32'h000);
        mouse_btn_id = 2'd2; mouse_on_btn = 1'b1; mouse_left = 1'b0;
        wait3();
        chk("b2_hover", 32'(pixel_out), 32'h32E);
        mouse_left = 1'b1;
        wait3();
        chk("b2_press", 32'(pixel_out), 32'hDD2);
        mouse_left = 1'b0;
        step();
        chk("b2_pulse", 32'(btn_click), 32'b0100);
        step();
        chk("b2_pulse_end", 32'(btn_click), 32'd0);
        wait3();
        chk("b2_rehover", 32'(pixel_out), 32'h32E);
        chk("b2_clicks", 32'(click_cnt), 32'd1);

        // Press on button 1, drag to button 3, release: no click, button 3 never pressed
        click_cnt = 0; h_cnt = 10'd6;
        mouse_btn_id = 2'd1;
        wait3();
        mouse_left = 1'b1;
        wait3();
        chk("drag_b1_press", 32'(pixel_out), 32'hDD2);
        mouse_btn_id = 2'd3;
        wait3();
        h_cnt = 10'd10;
        wait3();
        chk("drag_b3_idle", 32'(pixel_out), 32'h000);
        mouse_left = 1'b0;
        wait3();
        chk("drag_b3_hover", 32'(pixel_out), 32'h32E);
        h_cnt = 10'd6;
        wait3();
        chk("drag_b1_idle", 32'(pixel_out), 32'h000);
        chk("drag_clicks", 32'(click_cnt), 32'd0);

        // Blink with BLINK_FRAMES=2 on button 0 (code 2 at h=4)
        mouse_on_btn = 1'b0; h_cnt = 10'd4; v_cnt = 10'd0;
        do_reset();
        btn_status = 8'b01; video_valid = 1'b1;
        wait3();
        chk("blink_start", 32'(pixel_out), 32'h000);
        for (int f = 0; f < 6; f++) begin
            logic [11:0] exp_b [6];
            exp_b = '{12'h000, 12'h7FF, 12'h7FF, 12'h000, 12'h000, 12'h7FF};
            h_cnt = 10'd0;
            for (int c = 0; c < ((f == 0) ? 3 : 1); c++) step();
            h_cnt = 10'd4;
            wait3();
            chk($sformatf("blink_f%0d", f + 1), 32'(pixel_out), 32'(exp_b[f]));
        end

        // Linked button ignores the mouse and never clicks
        btn_status = 8'b11; click_cnt = 0;
        wait3();
        chk("link_idle", 32'(pixel_out), 32'h1E1);
        mouse_btn_id = 2'd0; mouse_on_btn = 1'b1; mouse_left = 1'b0;
        wait3();
        mouse_left = 1'b1;
        wait3();
        chk("link_press", 32'(pixel_out), 32'h1E1);
        mouse_left = 1'b0;
        wait3();
        chk("link_release", 32'(pixel_out), 32'h1E1);
        chk("link_clicks", 32'(click_cnt), 32'd0);

        // Reset mid-line: flush, FSMs back to IDLE, no stale pixel
        btn_status = '0; h_cnt = 10'd8; mouse_btn_id = 2'd2;
        wait3();
        chk("mid_pre", 32'(pixel_out), 32'h32E);
        rst = 1'b1; mouse_left = 1'b1;
        step();
        chk("mid_rst_pix",   32'(pixel_out), 32'h000);
        chk("mid_rst_vld",   32'(pixel_valid), 32'd0);
        chk("mid_rst_addr",  32'(mem_addr), 32'd0);
        chk("mid_rst_click", 32'(btn_click), 32'd0);
        rst = 1'b0; video_valid = 1'b1;
        step();
        chk("mid_vld_c1", 32'(pixel_valid), 32'd0);
        step();
        chk("mid_vld_c2", 32'(pixel_valid), 32'd0);
        step();
        chk("mid_vld_c3", 32'(pixel_valid), 32'd1);
        chk("mid_fsm_idle", 32'(pixel_out), 32'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
